matrix_frame_buffer: RTL

//  Double-buffered 8x8 frame store upstream of the column-scan LED driver FSMs.
//  A writer (pattern/animation sequencer) fills the back bank one column byte at a time, then commits.
//  The block swaps banks only on a scan frame boundary, so the displayed 64-bit frame never tears mid-scan.

---
 rtl/matrix_frame_buffer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/matrix_frame_buffer.sv
// ============================================================================
// matrix_frame_buffer : double-buffered 8x8 LED frame store, swaps banks only
//                       on a scan frame boundary. Optional FB_MIN_HOLD_EN
//                       enforces a minimum display time per committed image.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_frame_buffer #(
  parameter int         HOLD_FRAMES = 4,
  parameter logic [7:0] BLANK_BYTE  = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  wr_col,
  input  logic [7:0]  wr_data,
  input  logic        commit,
  output logic        wr_ready,
  input  logic        frame_tick,
  output logic [63:0] frame,
  output logic        swap_pulse,
  output logic        dirty
);

  localparam logic [63:0] c_BLANK = {8{BLANK_BYTE}};

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t      r_state;
  logic [63:0] r_bank0;
  logic [63:0] r_bank1;
  logic        r_front_sel;
  logic [63:0] r_frame;
  logic        r_swap_pulse;
  logic        r_dirty;

  logic [63:0] w_back;
  logic [63:0] w_back_wr;
  logic        w_write;
  logic        w_hold_ok;
  logic        w_swap;

  assign w_back  = r_front_sel ? r_bank0 : r_bank1;
  assign w_write = (r_state == ST_IDLE) && wr_en;
  assign w_swap  = (r_state == ST_PENDING) && frame_tick && w_hold_ok;

  // Column 0 occupies the most significant byte.
  always_comb begin
    w_back_wr = w_back;
    for (int c = 0; c < 8; c++) begin
      if (wr_col == 3'(c))
        w_back_wr[63-8*c -: 8] = wr_data;
    end
  end

`ifdef FB_MIN_HOLD_EN
  localparam int               c_HCW  = $clog2(HOLD_FRAMES + 1);
  localparam logic [c_HCW-1:0] c_HOLD = c_HCW'(HOLD_FRAMES);

  logic [c_HCW-1:0] r_hold_cnt;

  assign w_hold_ok = (r_hold_cnt == c_HOLD);

  // Starts saturated so the first commit after reset is not delayed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_hold_cnt <= c_HOLD;
    else if (w_swap)
      r_hold_cnt <= '0;
    else if (frame_tick && (r_hold_cnt != c_HOLD))
      r_hold_cnt <= r_hold_cnt + 1'b1;
  end
`else
  // No minimum hold: always permitted (HOLD_FRAMES is legal by construction).
  assign w_hold_ok = (HOLD_FRAMES >= 1);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_bank0      <= c_BLANK;
      r_bank1      <= c_BLANK;
      r_front_sel  <= 1'b0;
      r_frame      <= c_BLANK;
      r_swap_pulse <= 1'b0;
      r_dirty      <= 1'b0;
    end else begin
      r_swap_pulse <= w_swap;
      case (r_state)
        ST_IDLE: begin
          if (w_write) begin
            if (r_front_sel) r_bank0 <= w_back_wr;
            else             r_bank1 <= w_back_wr;
            r_dirty <= 1'b1;
          end
          if (commit)
            r_state <= ST_PENDING;
        end
        ST_PENDING: begin
          if (w_swap) begin
            // Old front bank becomes the new back bank, preloaded with the
            // image now on display so later writes are incremental edits.
            if (r_front_sel) r_bank1 <= r_bank0;
            else             r_bank0 <= r_bank1;
            r_front_sel <= ~r_front_sel;
            r_frame     <= w_back;
            r_dirty     <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wr_ready   = (r_state == ST_IDLE);
  assign frame      = r_frame;
  assign swap_pulse = r_swap_pulse;
  assign dirty      = r_dirty;

endmodule

`default_nettype wire
